// File: rtl/i2s.sv
// i2s: I2S transmitter. Serialises one stereo frame (left word, then right
// word, two's-complement, MSB first) per 2*WIDTH SCLK periods.
// SCLK runs at clk/2. WS and SD change only when SCLK falls, so a receiver
// can sample them on the rising edge of SCLK.
//
// Ports
//   clk   : system clock; all logic runs on its rising edge
//   rst   : asynchronous reset, active high
//   Tx    : stereo frame, sampled at frame start {left, right}
//   ready : one-clk strobe; Tx is sampled at the edge that ends it
//   SCLK  : serial bit clock
//   WS    : word select (0 = left, 1 = right)
//   SD    : serial data
module i2s #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2*WIDTH-1:0]   Tx,
   output logic                 ready,
   output logic                 SCLK,
   output logic                 WS,
   output logic                 SD
);

   localparam int unsigned FW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(FW);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [FW-1:0]   shreg, shreg_nxt;
   logic            sclk_nxt, ws_nxt, sd_nxt, ready_nxt;
   logic [CW-1:0]   n_c;

   // Index of the next fall edge within the frame; cnt holds the index of
   // the most recent one, and IDLE means the next fall edge starts a frame.
   assign n_c = (state == IDLE || cnt == CW'(FW - 1)) ? '0 : cnt + CW'(1);

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
         SCLK  <= 1'b0;
         WS    <= 1'b0;
         SD    <= 1'b0;
         ready <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         shreg <= shreg_nxt;
         SCLK  <= sclk_nxt;
         WS    <= ws_nxt;
         SD    <= sd_nxt;
         ready <= ready_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shreg_nxt = shreg;
      sclk_nxt  = ~SCLK;
      ws_nxt    = WS;
      sd_nxt    = SD;
      ready_nxt = ready;

      if (SCLK) begin
         // Fall edge. The register rotates left once per bit, so its MSB is
         // the next bit to send; after 2*WIDTH-1 rotations the MSB is the
         // right-word LSB, which goes out at the following frame start.
         ready_nxt = 1'b0;
         cnt_nxt   = n_c;
         sd_nxt    = shreg[FW-1];
         if (n_c == '0) begin
            shreg_nxt = Tx;
            ws_nxt    = 1'b0;
         end else begin
            shreg_nxt = {shreg[FW-2:0], shreg[FW-1]};
         end
         if (n_c == CW'(WIDTH)) begin
            ws_nxt = 1'b1;
         end

         case (state)
            IDLE:    state_nxt = LEFT;
            LEFT:    if (n_c == CW'(WIDTH)) state_nxt = RIGHT;
            RIGHT:   if (n_c == '0)         state_nxt = LEFT;
            default: state_nxt = IDLE;
         endcase
      end else begin
         // Rising SCLK: request a frame just before the frame-start edge
         ready_nxt = (n_c == '0);
      end
   end

endmodule

// File: tb/tb_i2s.sv
// tb_i2s: directed self-checking bench for i2s at WIDTH=16 and WIDTH=8.
module tb_i2s;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] tx = '0;
   logic [15:0] tx8 = '0;
   logic        ready, sclk, ws, sd;
   logic        ready8, sclk8, ws8, sd8;

   int checks = 0;
   int failures = 0;

   i2s #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .Tx(tx),
      .ready(ready), .SCLK(sclk), .WS(ws), .SD(sd)
   );

   i2s #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .Tx(tx8),
      .ready(ready8), .SCLK(sclk8), .WS(ws8), .SD(sd8)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Hold reset, load the frames, release on a falling edge so the next
   // rising edge is edge 1 after release.
   task automatic do_reset(input logic [31:0] t, input logic [15:0] t8);
      rst = 1'b1;
      tx  = t;
      tx8 = t8;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Expected WS after edge e: last fall edge was e-2 rounded down to even
   function automatic logic exp_ws(input int e, input int w);
      if (e < 2) return 1'b0;
      return (((e - 2) / 2) % (2 * w)) >= w;
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({sclk, ws, sd, ready} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_initial: got %b expected 0000", {sclk, ws, sd, ready});
      end
      rst = 1'b0;
      repeat (35) tick();
      checks++;
      if ({sclk, ws} !== 2'b11) begin
         failures++;
         $display("FAIL reset_midframe_pre: got sclk,ws=%b expected 11", {sclk, ws});
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({sclk, ws, sd, ready} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_async: got %b expected 0000", {sclk, ws, sd, ready});
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if ({sclk, ws, sd, ready, sclk8, ws8, sd8, ready8} !== 8'b0) begin
            failures++;
            $display("FAIL reset_hold: cycle %0d got %b expected 00000000", k,
                     {sclk, ws, sd, ready, sclk8, ws8, sd8, ready8});
         end
      end
   endtask

   task automatic test_clock;
      do_reset(32'h0, 16'h0);
      for (int e = 1; e <= 130; e++) begin
         tick();
         checks++;
         if (sclk !== 1'(e % 2)) begin
            failures++;
            $display("FAIL clock_sclk: edge %0d got %b expected %b", e, sclk, 1'(e % 2));
         end
         checks++;
         if (ready !== (e % 64 == 1)) begin
            failures++;
            $display("FAIL clock_ready: edge %0d got %b expected %b", e, ready, (e % 64 == 1));
         end
      end
   endtask

   task automatic test_data;
      logic [32:0] exp33;
      exp33 = {1'b0, 32'h00C2AA59};
      do_reset(32'h00C2AA59, 16'h0);
      for (int e = 1; e <= 66; e++) begin
         tick();
         checks++;
         if (ws !== exp_ws(e, 16)) begin
            failures++;
            $display("FAIL data_ws: edge %0d got %b expected %b", e, ws, exp_ws(e, 16));
         end
         if (e % 2 == 0) begin
            checks++;
            if (sd !== exp33[32 - (e - 2) / 2]) begin
               failures++;
               $display("FAIL data_sd: n=%0d got %b expected %b", (e - 2) / 2, sd,
                        exp33[32 - (e - 2) / 2]);
            end
         end
      end
   endtask

   task automatic test_sampling;
      logic [32:0] exp33;
      logic        exp_sd;
      int          i;
      exp33 = {1'b0, 32'h00C2AA59};
      do_reset(32'h00C2AA59, 16'h0);
      for (int e = 1; e <= 130; e++) begin
         tick();
         if (e == 21) tx = 32'hFFFF0000;
         if (e % 2 == 0) begin
            i = (e - 2) / 2;
            if (i <= 32) exp_sd = exp33[32 - i];
            else exp_sd = (i - 32 <= 16) && (i < 64);
            checks++;
            if (sd !== exp_sd) begin
               failures++;
               $display("FAIL sampling_sd: fall %0d got %b expected %b", i, sd, exp_sd);
            end
         end
      end
   endtask

   task automatic test_param;
      logic [16:0] exp17;
      exp17 = {1'b0, 16'hA55A};
      do_reset(32'h0, 16'hA55A);
      for (int e = 1; e <= 66; e++) begin
         tick();
         checks++;
         if (ready8 !== (e % 32 == 1)) begin
            failures++;
            $display("FAIL param_ready: edge %0d got %b expected %b", e, ready8, (e % 32 == 1));
         end
         checks++;
         if (ws8 !== exp_ws(e, 8)) begin
            failures++;
            $display("FAIL param_ws: edge %0d got %b expected %b", e, ws8, exp_ws(e, 8));
         end
         if (e % 2 == 0 && (e - 2) / 2 <= 16) begin
            checks++;
            if (sd8 !== exp17[16 - (e - 2) / 2]) begin
               failures++;
               $display("FAIL param_sd: n=%0d got %b expected %b", (e - 2) / 2, sd8,
                        exp17[16 - (e - 2) / 2]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_clock();
      test_data();
      test_sampling();
      test_param();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2s.md
I2S -- requirements
Module: i2s

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving bits per channel word (legal WIDTH >= 2).
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port Tx, input, 2*WIDTH bits: stereo frame; Tx[2*WIDTH-1:WIDTH] is the left word and Tx[WIDTH-1:0] is the right word.
REQ-005 SHALL have port ready, output, 1 bit: frame-request strobe; Tx is sampled at the clk edge that ends the ready-high cycle.
REQ-006 SHALL have port SCLK, output, 1 bit: I2S serial bit clock.
REQ-007 SHALL have port WS, output, 1 bit: word select; 0 means left, 1 means right.
REQ-008 SHALL have port SD, output, 1 bit: serial data, two's-complement, MSB first.
REQ-009 SHALL register all outputs, with no combinational path from Tx to any output.

Function
REQ-010 SHALL toggle SCLK on every rising clk edge while rst=0, so SCLK = clk/2 with 50% duty.
REQ-011 SHALL define a "fall edge" as a clk edge at which SCLK goes 1->0; WS and SD SHALL change only on fall edges, so the receiver samples them on SCLK rising.
REQ-012 SHALL number fall edges within a frame as n = 0..2*WIDTH-1; each frame lasts 2*WIDTH SCLK periods (4*WIDTH clk cycles).
REQ-013 SHALL, at fall edge n=0 (frame start), capture Tx into an internal 2*WIDTH-bit shift register and drive WS<=0.
REQ-014 SHALL, at n=0, drive SD<=bit 0 of the previously captured frame (right LSB); this bit is 0 for the first frame after reset.
REQ-015 SHALL, at fall edge n = 1..2*WIDTH-1, drive SD<=captured[2*WIDTH-n]; this is the standard one-SCLK delay between a WS change and the word MSB.
REQ-016 SHALL drive WS<=1 at fall edge n=WIDTH and hold WS=1 until the next n=0.
REQ-017 SHALL assert ready=1 at the clk edge where SCLK goes 0->1 immediately before each frame-start fall edge, and deassert it at that frame-start edge, giving exactly one clk cycle high per frame.
REQ-018 SHALL sample Tx only at frame-start edges; Tx changes at any other time SHALL NOT affect the frame in progress.
REQ-019 SHALL implement the state machine IDLE -> LEFT -> RIGHT -> LEFT ...:
- IDLE is entered on reset.
- IDLE goes to LEFT at the first fall edge after reset.
- LEFT goes to RIGHT at n=WIDTH.
- RIGHT goes to LEFT at the next n=0.
REQ-020 SHALL keep a bit counter of width ceil(log2(2*WIDTH)) that wraps from 2*WIDTH-1 to 0 at the frame-start edge.
REQ-021 SHALL run continuously once reset is released, with no gaps between frames and no stall input.

Reset
REQ-022 SHALL, while rst=1 and independent of clk, force SCLK=0, WS=0, SD=0 and ready=0, clear the shift register and counter, and select IDLE.
REQ-023 SHALL timestamp the first edges after reset release as follows:
- the first rising clk edge with rst=0 sets SCLK=1 and ready=1;
- the second is frame-start fall edge n=0, which captures Tx.
REQ-024 SHALL, when rst asserts mid-frame, abort the frame immediately; after release, operation SHALL restart per REQ-023 with SD=0 at n=0.

Verification
REQ-025 Reset scenario: assert rst mid-frame with clk running -> SCLK, WS, SD and ready are all 0 before the next clk edge and remain 0 while rst=1.
REQ-026 Clock scenario: release reset -> SCLK period is 2 clk cycles; ready is high for exactly 1 clk cycle every 64 clk cycles (WIDTH=16), first high after clk edge 1.
REQ-027 Data scenario: hold Tx=32'h00C2AA59 -> SD on fall edges n=0..32 is 0, then 0000000011000010, then 1010101001011001, where the final 1 appears at the next frame's n=0.
REQ-028 WS scenario: same Tx -> WS is 0 for 16 SCLK periods starting at n=0 and 1 for 16 periods starting at n=16; the SD MSB of each word appears one SCLK after the WS change.
REQ-029 Sampling scenario: change Tx to 32'hFFFF0000 mid-frame -> the current frame is unchanged, and the next frame sends 16 ones while WS=0 and 16 zeros while WS=1.
REQ-030 Parameter scenario: WIDTH=8 with Tx=16'hA55A -> frame is 16 SCLK periods, and SD after n=0 is 10100101 then 01011010.
